// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and frame defaults common to transmitter and receiver.
package uart_pkg;

    localparam int unsigned WORD_SIZE    = 8;
    localparam int unsigned CLKS_PER_BIT = 8;
    localparam int unsigned BC_SIZE      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SENDING = 2'd2
    } uart_state_t;

    // Baud counter width: clog2(clks_per_bit), never narrower than one bit.
    function automatic int unsigned baud_width(input int unsigned cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_datapath.sv
// Transmit datapath: double-buffered holding register, frame shift register, baud and bit counters.
module uart_tx_datapath
    import uart_pkg::*;
#(
    parameter int unsigned word_size    = WORD_SIZE,
    parameter int unsigned clks_per_bit = CLKS_PER_BIT,
    parameter int unsigned bc_size      = BC_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] i_data_bus,
    input  logic                 i_load_xmt_datareg,
    input  logic                 i_load_shftreg,
    input  logic                 i_start,
    input  logic                 i_shift,
    input  logic                 i_clear,
    input  logic                 i_count,
    output logic                 o_serial_out,
    output logic                 o_bc_eq_last_c,
    output logic                 o_baud_done_c
);

    localparam int unsigned BAUD_W = baud_width(clks_per_bit);

    logic [word_size-1:0] r_xmt_datareg;
    logic [word_size:0]   r_xmt_shftreg;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [bc_size-1:0]   r_bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xmt_datareg <= '0;
        end else if (i_load_xmt_datareg) begin
            r_xmt_datareg <= i_data_bus;
        end
    end

    // Bit 0 is the line; the LSB slot of a freshly loaded word holds the idle 1 until start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xmt_shftreg <= '1;
        end else if (i_load_shftreg) begin
            r_xmt_shftreg <= {r_xmt_datareg, 1'b1};
        end else if (i_start) begin
            r_xmt_shftreg[0] <= 1'b0;
        end else if (i_shift) begin
            r_xmt_shftreg <= {1'b1, r_xmt_shftreg[word_size:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_clear) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_shift) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + bc_size'(1);
        end else if (i_count) begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
        end
    end

    assign o_serial_out   = r_xmt_shftreg[0];
    assign o_baud_done_c  = (r_baud_cnt == BAUD_W'(clks_per_bit - 1));
    assign o_bc_eq_last_c = (r_bit_cnt == bc_size'(word_size + 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter top: control FSM driving the transmit datapath (start, data LSB-first, stop).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned word_size    = WORD_SIZE,
    parameter int unsigned clks_per_bit = CLKS_PER_BIT,
    parameter int unsigned bc_size      = BC_SIZE
) (
    input  logic                 Clock,
    input  logic                 rst_b,
    input  logic [word_size-1:0] Data_Bus,
    input  logic                 Load_XMT_datareg,
    input  logic                 Byte_ready,
    input  logic                 T_byte,
    output logic                 Serial_out,
    output logic                 Tx_busy
);

    uart_state_t r_state;
    uart_state_t w_next_state;
    logic        r_tx_busy;

    logic w_load_shftreg;
    logic w_start;
    logic w_shift;
    logic w_clear;
    logic w_count;
    logic w_bc_eq_last;
    logic w_baud_done;
    logic w_serial;

    always_ff @(posedge Clock or posedge rst_b) begin
        if (rst_b) begin
            r_state   <= IDLE;
            r_tx_busy <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tx_busy <= (w_next_state != IDLE);
        end
    end

    // Stop bit is the last baud period of the last bit count; leave without shifting.
    always_comb begin
        w_next_state   = r_state;
        w_load_shftreg = 1'b0;
        w_start        = 1'b0;
        w_shift        = 1'b0;
        w_clear        = 1'b0;
        w_count        = 1'b0;
        case (r_state)
            IDLE: begin
                if (Byte_ready) begin
                    w_load_shftreg = 1'b1;
                    w_next_state   = WAITING;
                end
            end
            WAITING: begin
                if (T_byte) begin
                    w_start      = 1'b1;
                    w_clear      = 1'b1;
                    w_next_state = SENDING;
                end
            end
            SENDING: begin
                if (!w_baud_done) begin
                    w_count = 1'b1;
                end else if (w_bc_eq_last) begin
                    w_clear      = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_shift = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    uart_tx_datapath #(
        .word_size    (word_size),
        .clks_per_bit (clks_per_bit),
        .bc_size      (bc_size)
    ) u_datapath (
        .clk                (Clock),
        .rst                (rst_b),
        .i_data_bus         (Data_Bus),
        .i_load_xmt_datareg (Load_XMT_datareg),
        .i_load_shftreg     (w_load_shftreg),
        .i_start            (w_start),
        .i_shift            (w_shift),
        .i_clear            (w_clear),
        .i_count            (w_count),
        .o_serial_out       (w_serial),
        .o_bc_eq_last_c     (w_bc_eq_last),
        .o_baud_done_c      (w_baud_done)
    );

    assign Serial_out = w_serial;
    assign Tx_busy    = r_tx_busy;

endmodule
